riscv_multicycle_ctrl: RTL and testbench

//  Multicycle main controller FSM. Drives alu_control, datapath mux selects and write enables.

---
 rtl/riscv_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 38 +++
 rtl/riscv_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg : state, opcode, ALU and datapath-select encodings for the
//                  multicycle RISC-V controller.                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Only add/sub, slt, or and and are implemented for R/I-type arithmetic.
  function automatic logic alu_funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder : maps (alu_op, funct3, funct7b5, op5) onto alu_control.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUCTL_ADD;
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi never subtracts: funct7b5 is part of its immediate
          3'b000:  alu_control = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_multicycle_ctrl : multicycle main controller FSM with branch resolution.
// Optional feature macro: BRANCH_EXT_EN (full bne/blt/bge/bltu/bgeu support). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       n,
  input  logic       c,
  input  logic       v,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic [1:0] alu_op;
  logic [2:0] alu_dec;
  logic       taken;
  logic       branch_ok;

`ifdef BRANCH_EXT_EN
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = n ^ v;
      3'b101:  taken = ~(n ^ v);
      3'b110:  taken = ~c;
      3'b111:  taken = c;
      default: taken = 1'b0;
    endcase
  end
  assign branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
  logic unused_flags;
  assign unused_flags = n ^ c ^ v;
  assign taken        = zero;
  assign branch_ok    = (funct3 == 3'b000);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:  next_state = alu_funct3_ok(funct3) ? S_EXECR : S_ILLEGAL;
          OP_ITYPE:  next_state = alu_funct3_ok(funct3) ? S_EXECI : S_ILLEGAL;
          OP_BRANCH: next_state = branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:    next_state = S_JAL;
          default:   next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECR,
      S_EXECI:    next_state = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BRANCH,
      S_JAL:      next_state = S_FETCH;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_dec)
  );

  // Moore decode; reset overrides every enable and select in the same cycle.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = taken;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
    alu_control = alu_dec;
    if (rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = 3'b000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_multicycle_ctrl : directed + random bench with an instruction-level
//                            reference model of the controller outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, n = 1'b0, c = 1'b0, v = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [16:0] got;

  int vectors = 0;
  int miscompares = 0;

  typedef enum {K_LOAD, K_STORE, K_R, K_I, K_BR, K_JAL, K_BAD} kind_e;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .n(n), .c(c), .v(v),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write, illegal};

  function automatic logic branch_legal(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return !(f3 == 3'd2 || f3 == 3'd3);
`else
    return f3 == 3'd0;
`endif
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic z, nn, cc, vv;
    {z, nn, cc, vv} = fl;
`ifdef BRANCH_EXT_EN
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return nn != vv;
      3'd5: return nn == vv;
      3'd6: return !cc;
      3'd7: return cc;
      default: return 1'b0;
    endcase
`else
    return z;
`endif
  endfunction

  function automatic kind_e classify(input logic [6:0] o, input logic [2:0] f3);
    logic alu_ok;
    alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return alu_ok ? K_R : K_BAD;
      7'b0010011: return alu_ok ? K_I : K_BAD;
      7'b1100011: return branch_legal(f3) ? K_BR : K_BAD;
      7'b1101111: return K_JAL;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic int instr_cycles(input kind_e k);
    case (k)
      K_LOAD:        return 5;
      K_STORE, K_R, K_I: return 4;
      default:       return 3;
    endcase
  endfunction

  // Expected output vector for cycle 'step' of one instruction.
  function automatic logic [16:0] expect_vec(input kind_e k, input int step, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7,
                                             input logic [3:0] fl);
    logic pw, as, mw, iw, rw, il;
    logic [1:0] rs, sa, sb, is;
    logic [2:0] ac, ex;
    {pw, as, mw, iw, rw, il} = 6'd0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; ac = 3'd0;
    is = (o == 7'b0100011) ? 2'd1 : (o == 7'b1100011) ? 2'd2 : (o == 7'b1101111) ? 2'd3 : 2'd0;
    ex = (f3 == 3'd0) ? ((o[5] && f7) ? 3'd1 : 3'd0) :
         (f3 == 3'd2) ? 3'd5 : (f3 == 3'd6) ? 3'd3 : 3'd2;
    if (step == 0) begin
      iw = 1; pw = 1; sb = 2'd2; rs = 2'd2;
    end else if (step == 1) begin
      sa = 2'd1; sb = 2'd1;
    end else begin
      case (k)
        K_LOAD: if (step == 2) begin sa = 2'd2; sb = 2'd1; end
                else if (step == 3) as = 1;
                else begin rs = 2'd1; rw = 1; end
        K_STORE: if (step == 2) begin sa = 2'd2; sb = 2'd1; end
                 else begin as = 1; mw = 1; end
        K_R: if (step == 2) begin sa = 2'd2; ac = ex; end
             else rw = 1;
        K_I: if (step == 2) begin sa = 2'd2; sb = 2'd1; ac = ex; end
             else rw = 1;
        K_BR: begin sa = 2'd2; ac = 3'd1; pw = branch_taken(f3, fl); end
        K_JAL: begin sa = 2'd1; sb = 2'd2; pw = 1; rw = 1; end
        default: il = 1;
      endcase
    end
    return {pw, as, mw, iw, rs, sa, sb, is, ac, rw, il};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the last checked cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int flags, input int max_steps);
    kind_e k;
    int len;
    logic [3:0] fl;
    op = o; funct3 = f3; funct7b5 = f7;
    k = classify(o, f3);
    len = (k == K_BAD) ? 12 : instr_cycles(k);
    if (max_steps < len) len = max_steps;
    for (int s = 0; s < len; s++) begin
      fl = (flags < 0) ? 4'($urandom) : 4'(flags);
      {zero, n, c, v} = fl;
      @(negedge clk);
      check($sformatf("op%b_f3%0d_step%0d", o, f3, s), expect_vec(k, s, o, f3, f7, fl));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic il0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset", {16'd0, (i == 0) ? il0 : 1'b0});
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    logic [2:0] f3;
    logic [2:0] good_f3 [4];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    good_f3 = '{3'd0, 3'd2, 3'd6, 3'd7};

    do_reset(1'b0);

    run_instr(7'b0110011, 3'd0, 1'b0, -1, 99);   // add
    run_instr(7'b0110011, 3'd0, 1'b1, -1, 99);   // sub
    run_instr(7'b0010011, 3'd0, 1'b1, -1, 99);   // addi, f7b5 ignored
    run_instr(7'b0110011, 3'd2, 1'b0, -1, 99);   // slt
    run_instr(7'b0010011, 3'd6, 1'b0, -1, 99);   // ori
    run_instr(7'b0110011, 3'd7, 1'b0, -1, 99);   // and
    run_instr(7'b0000011, 3'd2, 1'b0, -1, 99);   // lw
    run_instr(7'b0100011, 3'd2, 1'b0, -1, 99);   // sw
    run_instr(7'b1100011, 3'd0, 1'b0, 4'b1000, 99); // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 4'b0000, 99); // beq not taken
    run_instr(7'b1101111, 3'd0, 1'b0, -1, 99);   // jal
`ifdef BRANCH_EXT_EN
    run_instr(7'b1100011, 3'd4, 1'b0, 4'b0100, 99); // blt taken
    run_instr(7'b1100011, 3'd7, 1'b0, 4'b0000, 99); // bgeu not taken
    run_instr(7'b1100011, 3'd3, 1'b0, -1, 99);      // reserved funct3
    do_reset(1'b1);
`else
    run_instr(7'b1100011, 3'd1, 1'b0, -1, 99);      // bne unsupported
    do_reset(1'b1);
`endif

    run_instr(7'b1111111, 3'd0, 1'b0, -1, 99);      // unknown opcode, 10 idle cycles
    do_reset(1'b1);

    // Reset asserted while in MEMWRITE kills the store in that very cycle.
    run_instr(7'b0100011, 3'd2, 1'b0, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_memwrite", 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_instr(7'b0100011, 3'd2, 1'b0, -1, 99);

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      o = (sel < 6) ? ops[sel] : 7'($urandom);
      f3 = 3'($urandom);
      if ((sel == 2 || sel == 3) && $urandom_range(0, 9) < 8)
        f3 = good_f3[$urandom_range(0, 3)];
      run_instr(o, f3, 1'($urandom), -1, 99);
      if (classify(o, f3) == K_BAD)
        do_reset(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, required finish within 500000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
